// File: rtl/sdram_access_arbiter.sv
// SDRAM port arbiter: loader writes, VGA reads and auto-refresh
// share one controller port in bounded bursts.
module sdram_access_arbiter #(
  parameter int BURST_LEN        = 8,
  parameter int REFRESH_INTERVAL = 1040,
  parameter int CNT_W            = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic wr_req,
  input  logic rd_req,
  input  logic rd_urgent,
  input  logic word_done,
  input  logic refresh_done,
  output logic wr_grant,
  output logic rd_grant,
  output logic sdram_write_mode,
  output logic sdram_read_mode,
  output logic refresh_req,
  output logic refresh_overrun,
  output logic busy
);

  localparam int WC_W = $clog2(BURST_LEN) + 1;
  localparam logic [WC_W-1:0] LAST_WORD =
    WC_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TMR_TOP =
    CNT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_WR,
    GRANT_RD,
    REFRESH
  } state_t;

  state_t          state;
  logic [WC_W-1:0] word_cnt;
  logic [CNT_W-1:0] timer;
  logic            pending;
  logic            last_rd;
  logic            expire;
  logic            take_refresh;
  logic            last_word;
  logic            wr_end;
  logic            rd_end;

  assign expire       = init_done && (timer == TMR_TOP);
  assign take_refresh = (state == IDLE) && init_done && pending;
  assign last_word    = word_done && (word_cnt == LAST_WORD);
  assign wr_end       = !wr_req || last_word;
  assign rd_end       = !rd_req || last_word;

  assign sdram_write_mode = wr_grant;
  assign sdram_read_mode  = rd_grant;

  // Expiry wins over the clear taken on refresh entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer           <= '0;
      pending         <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      if (!init_done) begin
        timer   <= '0;
        pending <= 1'b0;
      end else begin
        timer <= expire ? '0 : timer + 1'b1;
        if (expire)
          pending <= 1'b1;
        else if (take_refresh)
          pending <= 1'b0;
      end
      if (expire && pending)
        refresh_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_cnt    <= '0;
      last_rd     <= 1'b0;
      wr_grant    <= 1'b0;
      rd_grant    <= 1'b0;
      refresh_req <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          word_cnt <= '0;
          if (init_done) begin
            if (pending) begin
              state       <= REFRESH;
              refresh_req <= 1'b1;
              busy        <= 1'b1;
            end else if (rd_req &&
                         (rd_urgent || !wr_req || !last_rd)) begin
              state    <= GRANT_RD;
              rd_grant <= 1'b1;
              busy     <= 1'b1;
            end else if (wr_req) begin
              state    <= GRANT_WR;
              wr_grant <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        GRANT_WR: begin
          if (wr_end) begin
            state    <= IDLE;
            word_cnt <= '0;
            last_rd  <= 1'b0;
            wr_grant <= 1'b0;
            busy     <= 1'b0;
          end else if (word_done) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        GRANT_RD: begin
          if (rd_end) begin
            state    <= IDLE;
            word_cnt <= '0;
            last_rd  <= 1'b1;
            rd_grant <= 1'b0;
            busy     <= 1'b0;
          end else if (word_done) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        REFRESH: begin
          if (refresh_done) begin
            state       <= IDLE;
            refresh_req <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter: vector table
// plus hand sequences for refresh, overrun and reset.
module tb_sdram_access_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  logic wr_req;
  logic rd_req;
  logic rd_urgent;
  logic word_done;
  logic refresh_done;
  logic wr_grant;
  logic rd_grant;
  logic sdram_write_mode;
  logic sdram_read_mode;
  logic refresh_req;
  logic refresh_overrun;
  logic busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit i, w, r, u, wd, rfd;
    bit wg, rg, rr;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sdram_access_arbiter #(
    .BURST_LEN(8),
    .REFRESH_INTERVAL(100),
    .CNT_W(11)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_done(init_done),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .rd_urgent(rd_urgent),
    .word_done(word_done),
    .refresh_done(refresh_done),
    .wr_grant(wr_grant),
    .rd_grant(rd_grant),
    .sdram_write_mode(sdram_write_mode),
    .sdram_read_mode(sdram_read_mode),
    .refresh_req(refresh_req),
    .refresh_overrun(refresh_overrun),
    .busy(busy)
  );

  // {wg, rg, rr, busy, wmode, rmode, overrun}
  function automatic logic [6:0] mk(bit wg, bit rg,
                                    bit rr, bit ovr);
    return {wg, rg, rr, wg | rg | rr, wg, rg, ovr};
  endfunction

  task automatic chk(string name, logic [6:0] exp);
    logic [6:0] got;
    got = {wr_grant, rd_grant, refresh_req, busy,
           sdram_write_mode, sdram_read_mode,
           refresh_overrun};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drv(bit i, bit w, bit r, bit u,
                     bit wd, bit rfd);
    init_done    = i;
    wr_req       = w;
    rd_req       = r;
    rd_urgent    = u;
    word_done    = wd;
    refresh_done = rfd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(bit i, bit w, bit r, bit u, bit wd,
                     bit rfd, bit wg, bit rg, bit rr);
    vec_t v;
    v.i = i; v.w = w; v.r = r; v.u = u;
    v.wd = wd; v.rfd = rfd;
    v.wg = wg; v.rg = rg; v.rr = rr;
    tbl.push_back(v);
  endtask

  task automatic add_burst(bit w, bit r, bit wg, bit rg);
    for (int k = 0; k < 7; k++)
      add(1, w, r, 0, 1, 0, wg, rg, 0);
    add(1, w, r, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // write burst, turnaround, word_done ignored in IDLE
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0);
    add_burst(1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0);
    add_burst(1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // round robin RD, WR, RD
    add(1, 1, 1, 0, 0, 0, 0, 1, 0);
    add_burst(1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    add_burst(1, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // urgent beats round robin, never preempts
    add(1, 1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0, 0, 0);
    // rd withdraws after 2 words
    add(1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    drv(0, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset", mk(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // held off while init_done low
    for (int k = 0; k < 2000; k++) begin
      step();
      chk("no_init", mk(0, 0, 0, 0));
    end

    foreach (tbl[n]) begin
      drv(tbl[n].i, tbl[n].w, tbl[n].r, tbl[n].u,
          tbl[n].wd, tbl[n].rfd);
      step();
      chk($sformatf("vec%0d", n),
          mk(tbl[n].wg, tbl[n].rg, tbl[n].rr, 0));
    end

    // expiry at word 3 of a write burst
    for (int k = 0; k <= 111; k++) begin
      bit w, wd, rfd, i;
      bit ewg, err;
      i   = (k <= 110);
      w   = (k >= 96 && k <= 109);
      wd  = (k >= 97 && k <= 104);
      rfd = (k == 108);
      drv(i, w, 0, 0, wd, rfd);
      step();
      ewg = (k >= 96 && k <= 103) || (k == 109);
      err = (k >= 105 && k <= 107);
      chk($sformatf("ref_mid_burst%0d", k),
          mk(ewg, 0, err, 0));
    end

    // refresh_done held off across two expiries
    for (int k = 0; k <= 360; k++) begin
      bit err, eov;
      drv(1, 0, 0, 0, 0, (k == 350) || (k == 352));
      step();
      err = (k >= 100 && k <= 349) || (k == 351);
      eov = (k >= 299);
      chk($sformatf("overrun%0d", k),
          mk(0, 0, err, eov));
    end
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk("overrun_sticky", mk(0, 0, 0, 1));

    // asynchronous reset mid-burst
    drv(1, 1, 0, 0, 0, 0);
    step();
    chk("pre_reset_grant", mk(1, 0, 0, 1));
    drv(1, 1, 0, 0, 1, 0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", mk(0, 0, 0, 0));
    #3;
    rst_n = 1'b1;

    // init_done falls mid-burst: burst completes, then idle
    drv(1, 1, 0, 0, 0, 0);
    step();
    chk("init_fall_grant", mk(1, 0, 0, 0));
    for (int k = 1; k <= 10; k++) begin
      drv(0, 1, 0, 0, k <= 8, 0);
      step();
      chk($sformatf("init_fall%0d", k),
          mk(k <= 7, 0, 0, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
